serial_adder: RTL

//  Bit-serial WIDTH-bit adder, built around the existing full_adder cell.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_if.sv | 14 +
 rtl/full_adder.sv | 11 +
 rtl/serial_adder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and serial_adder.
interface serial_adder_if #(parameter int WIDTH = 8) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell used as the serial adder's bit slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, carry held in a flop.
// Results appear on sum/cout only at completion, flagged by a one-cycle done.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_r;
    state_e           state_next_s;
    logic             load_s;
    logic             shift_s;
    logic             last_s;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] acc_sr;
    logic [WIDTH-1:0] acc_next_s;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_s;
    logic             fa_cout_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;

    full_adder u_bit (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .c    (carry_r),
        .s    (fa_s),
        .cout (fa_cout_s)
    );

    // New sum bits enter at the MSB so the LSB-first result ends up aligned.
    assign acc_next_s = {fa_s, acc_sr[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    load_s       = 1'b1;
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                shift_s = 1'b1;
                if (cnt_r == LAST) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand shifting, carry, bit counter and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            acc_sr  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s == SHIFT);
            done_r <= last_s;
            if (load_s) begin
                a_sr    <= bus.a;
                b_sr    <= bus.b;
                carry_r <= bus.cin;
                cnt_r   <= '0;
            end else if (shift_s) begin
                a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                acc_sr  <= acc_next_s;
                carry_r <= fa_cout_s;
                cnt_r   <= cnt_r + CW'(1);
                if (last_s) begin
                    sum_r  <= acc_next_s;
                    cout_r <= fa_cout_s;
                end
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule
